serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand/sum width in bits (legal range 2..32).
REQ-002 The block SHALL have the port input_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port input_reset, input, 1 bit: the reset, which is synchronous and active-high.
REQ-004 The block SHALL have the port input_start, input, 1 bit: request to begin an addition, sampled only in IDLE.
REQ-005 The block SHALL have the port input_a, input, WIDTH bits: operand A, captured when start is accepted.
REQ-006 The block SHALL have the port input_b, input, WIDTH bits: operand B, captured when start is accepted.
REQ-007 The block SHALL have the port input_carry, input, 1 bit: carry-in, captured when start is accepted.
REQ-008 The block SHALL have the port output_busy, output, 1 bit: high while in RUN or DONE.
REQ-009 The block SHALL have the port output_done, output, 1 bit: single-cycle pulse marking result valid.
REQ-010 The block SHALL have the port output_sum, output, WIDTH bits: registered sum.
REQ-011 The block SHALL have the port output_carry, output, 1 bit: registered carry-out.

Function
REQ-012 The block SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 In IDLE with input_start=1, the next edge SHALL load the A/B shift registers, load the carry flop from input_carry, clear the bit counter, and enter RUN.
REQ-014 In IDLE with input_start=0, the block SHALL hold all state.
REQ-015 In RUN, each edge SHALL add the LSBs of the A/B shift registers and the carry flop.
- The bit add SHALL use one full_adder instance: output_l is the sum bit, output_h is the next carry.
- The A and B shift registers SHALL shift right by one.
- The sum bit SHALL shift into the MSB of the sum shift register.
- The carry flop SHALL take output_h.
- The counter SHALL increment.
REQ-016 The RUN-to-DONE transition SHALL occur on the edge that processes bit WIDTH-1.
- On that edge, output_sum SHALL load the completed sum shift register, with that edge's sum bit in the MSB.
- On that edge, output_carry SHALL load that edge's output_h.
REQ-017 In DONE, output_done SHALL be 1 for exactly one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-018 Latency: if start is accepted at edge k, output_done SHALL be high in the cycle following edge k+WIDTH.
REQ-019 input_start SHALL be ignored in RUN and DONE; operands and carry-in SHALL not be re-sampled mid-operation.
REQ-020 output_sum and output_carry SHALL change only on the RUN-to-DONE edge and SHALL hold their value until the next completion or reset.
REQ-021 The result SHALL equal (input_a + input_b + input_carry) mod 2^(WIDTH+1), split as {output_carry, output_sum}.
REQ-022 Back-to-back operation: start asserted in the cycle after DONE (state IDLE) SHALL be accepted, giving a minimum issue interval of WIDTH+2 cycles.

Reset
REQ-023 While input_reset=1 at an edge, the block SHALL enter IDLE, and all other state SHALL clear to 0: output_busy, output_done, output_sum, output_carry, the shift registers, the counter and the carry flop.
REQ-024 Reset SHALL take priority over input_start and over any state transition.
REQ-025 Reset asserted during RUN SHALL abort the operation: no output_done pulse, output_sum=0, output_carry=0.

Verification (WIDTH=8)
REQ-026 Scenario: A=0xFF, B=0x01, cin=0 -> done 8 cycles after the accept edge, sum=0x00, carry=1.
REQ-027 Scenario: A=0x5A, B=0xA5, cin=1 -> sum=0x00, carry=1.
REQ-028 Scenario: A=0x00, B=0x00, cin=1 -> sum=0x01, carry=0; busy high for 9 cycles.
REQ-029 Scenario: A=0x12, B=0x34, then start pulsed with A=0xFF, B=0xFF during RUN -> sum=0x46, carry=0, exactly one done pulse.
REQ-030 Scenario: start 0x0F+0x01, then reset at RUN cycle 4 -> busy=0, no done, sum=0x00; a following start 0x03+0x04 -> sum=0x07.
REQ-031 Scenario: back-to-back 0x80+0x80 then 0x01+0x02, started the cycle after the first done -> first result 0x00/carry 1 held until second done, then 0x03/carry 0.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder is reused across WIDTH clock cycles,
// consuming the operands LSB first and assembling the sum MSB-down.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for input_start; operands captured on the accepting edge
// RUN   | one sum bit produced per edge, LSB first
// DONE  | result registered, output_done high for this single cycle

// Single-bit full adder: output_l is the sum bit, output_h the carry out.
module full_adder (
    input  logic input_a,
    input  logic input_b,
    input  logic input_carry,
    output logic output_l,
    output logic output_h
);

    // Sum and carry of three one-bit inputs.
    always_comb begin
        output_l = input_a ^ input_b ^ input_carry;
        output_h = (input_a & input_b) | (input_carry & (input_a ^ input_b));
    end

endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             input_clk,
    input  logic             input_reset,
    input  logic             input_start,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic             input_carry,
    output logic             output_busy,
    output logic             output_done,
    output logic [WIDTH-1:0] output_sum,
    output logic             output_carry
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Counter only has to reach WIDTH-1; the increment on the final edge
    // may wrap, which is harmless because the next accept clears it.
    localparam int              CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    // Holds the WIDTH-1 sum bits produced before the final edge; the final
    // edge's sum bit is concatenated on top when the result is registered.
    logic [WIDTH-2:0] sum_shift;
    logic [WIDTH-2:0] sum_shift_next;
    logic [CW-1:0]    count;
    logic             carry_q;
    logic             last_bit;
    logic             fa_l;
    logic             fa_h;

    full_adder u_full_adder (
        .input_a     (shift_a[0]),
        .input_b     (shift_b[0]),
        .input_carry (carry_q),
        .output_l    (fa_l),
        .output_h    (fa_h)
    );

    // Sum bits enter at the MSB end and move towards bit 0 each RUN edge.
    if (WIDTH > 2) begin : g_sum_wide
        assign sum_shift_next = {fa_l, sum_shift[WIDTH-2:1]};
    end else begin : g_sum_narrow
        assign sum_shift_next = fa_l;
    end

    // Next-state decode; an unused encoding falls back to IDLE.
    always_comb begin
        last_bit   = (count == LAST_BIT);
        state_next = state;
        case (state)
            IDLE:    if (input_start) state_next = RUN;
            RUN:     if (last_bit)    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset wins over any pending transition.
    always_ff @(posedge input_clk) begin
        if (input_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand shifters, bit counter and running carry.
    always_ff @(posedge input_clk) begin
        if (input_reset) begin
            shift_a   <= '0;
            shift_b   <= '0;
            sum_shift <= '0;
            count     <= '0;
            carry_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (input_start) begin
                        shift_a   <= input_a;
                        shift_b   <= input_b;
                        sum_shift <= '0;
                        count     <= '0;
                        carry_q   <= input_carry;
                    end
                end
                RUN: begin
                    shift_a   <= {1'b0, shift_a[WIDTH-1:1]};
                    shift_b   <= {1'b0, shift_b[WIDTH-1:1]};
                    sum_shift <= sum_shift_next;
                    count     <= count + CW'(1);
                    carry_q   <= fa_h;
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers update only on the edge that produces the MSB.
    always_ff @(posedge input_clk) begin
        if (input_reset) begin
            output_sum   <= '0;
            output_carry <= 1'b0;
        end else if (state == RUN && last_bit) begin
            output_sum   <= {fa_l, sum_shift};
            output_carry <= fa_h;
        end
    end

    // Status flags decoded straight from the state register.
    always_comb begin
        output_busy = (state == RUN) || (state == DONE);
        output_done = (state == DONE);
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder (WIDTH=8): directed scenarios plus random operands,
// checked against plain integer addition and a cycle-count timing model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_c;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_o;
    logic         carry_o;

    int tests = 0;
    int fails = 0;

    // Last completed result as the outside world should see it.
    logic [W:0] held = '0;

    serial_adder #(.WIDTH(W)) dut (
        .input_clk    (clk),
        .input_reset  (reset),
        .input_start  (start),
        .input_a      (op_a),
        .input_b      (op_b),
        .input_carry  (op_c),
        .output_busy  (busy),
        .output_done  (done),
        .output_sum   (sum_o),
        .output_carry (carry_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete addition. poke pulses start with all-ones operands during
    // RUN and holds start high through DONE, both of which must be ignored.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input bit poke);
        logic [W:0] full;
        int cnt;
        int busy_cnt;
        int done_cnt;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        op_c  = cin;
        tick();
        start = 1'b0;
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        op_c  = 1'($urandom);
        cnt = 0;
        busy_cnt = 0;
        done_cnt = 0;
        check("busy_after_accept", 33'(busy), 33'(1));
        if (busy) busy_cnt++;
        while (!done && cnt < 3 * W) begin
            check("result_held_in_run", 33'({carry_o, sum_o}), 33'(held));
            if (poke && cnt == 2) begin
                start = 1'b1;
                op_a  = '1;
                op_b  = '1;
                op_c  = 1'b1;
            end
            tick();
            start = 1'b0;
            cnt++;
            if (busy) busy_cnt++;
        end
        check("done_latency", 33'(cnt), 33'(W));
        if (done) done_cnt++;
        held = full;
        check("sum", 33'(sum_o), 33'(full[W-1:0]));
        check("carry_out", 33'(carry_o), 33'(full[W]));
        if (poke) start = 1'b1;
        tick();
        start = 1'b0;
        if (done) done_cnt++;
        check("done_pulses", 33'(done_cnt), 33'(1));
        check("busy_cycles", 33'(busy_cnt), 33'(W + 1));
        check("idle_after_done", 33'(busy), 33'(0));
        check("result_held_idle", 33'({carry_o, sum_o}), 33'(held));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        int done_seen;
        reset = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        op_c  = 1'b0;
        tick();
        tick();
        check("reset_busy", 33'(busy), 33'(0));
        check("reset_done", 33'(done), 33'(0));
        check("reset_sum", 33'(sum_o), 33'(0));
        check("reset_carry", 33'(carry_o), 33'(0));

        // Reset outranks a simultaneous start.
        start = 1'b1;
        op_a  = 8'h11;
        op_b  = 8'h22;
        tick();
        start = 1'b0;
        check("reset_beats_start", 33'(busy), 33'(0));
        reset = 1'b0;

        // Idle without start holds everything.
        tick();
        tick();
        check("idle_hold_busy", 33'(busy), 33'(0));
        check("idle_hold_sum", 33'({carry_o, sum_o}), 33'(0));

        do_op(8'hFF, 8'h01, 1'b0, 1'b0);
        do_op(8'h5A, 8'hA5, 1'b1, 1'b0);
        do_op(8'h00, 8'h00, 1'b1, 1'b0);
        do_op(8'h12, 8'h34, 1'b0, 1'b1);

        // Abort mid-RUN with reset.
        start = 1'b1;
        op_a  = 8'h0F;
        op_b  = 8'h01;
        op_c  = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("run_before_abort", 33'(busy), 33'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        held = '0;
        check("abort_busy", 33'(busy), 33'(0));
        check("abort_sum", 33'(sum_o), 33'(0));
        check("abort_carry", 33'(carry_o), 33'(0));
        done_seen = 0;
        for (int i = 0; i < W + 3; i++) begin
            if (done) done_seen++;
            tick();
        end
        check("abort_no_done", 33'(done_seen), 33'(0));
        do_op(8'h03, 8'h04, 1'b0, 1'b0);

        // Back-to-back: the second start is issued in the first IDLE cycle.
        do_op(8'h80, 8'h80, 1'b0, 1'b0);
        do_op(8'h01, 8'h02, 1'b0, 1'b0);

        // Random operands with occasional idle gaps.
        for (int n = 0; n < 20; n++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
